// File: rtl/led_pkg.sv
// led_pkg: definitions shared by the LED running-light chain.
//   KEY_*        one-hot encodings of the button debounce FSM states
//   MODE_*       run direction encoding, shared with the LED shifter
//   key_state_t  debounce FSM state type built on the KEY_* encodings
package led_pkg;

  localparam logic [3:0] KEY_IDLE   = 4'b0001;
  localparam logic [3:0] KEY_DEB_DN = 4'b0010;
  localparam logic [3:0] KEY_DOWN   = 4'b0100;
  localparam logic [3:0] KEY_DEB_UP = 4'b1000;

  localparam logic MODE_LEFT  = 1'b0;
  localparam logic MODE_RIGHT = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE   = KEY_IDLE,
    ST_DEB_DN = KEY_DEB_DN,
    ST_DOWN   = KEY_DOWN,
    ST_DEB_UP = KEY_DEB_UP
  } key_state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces an active-low push button.
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   key_i        raw asynchronous button, 0 = pressed
//   press_o      registered one-cycle pulse per accepted press
//   press_set_o  high in the cycle before press_o, so the parent can act
//                on the same edge that raises press_o (driven from registers only)
module key_debounce
  import led_pkg::*;
#(
  parameter int DEB_CYCLES = 20  // stable samples needed to accept a level change, >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o,
  output logic press_set_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_key_s;
  key_state_t       r_state;
  key_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_press;
  logic             w_press_next;

  assign w_key_s = r_sync2;

  // Synchroniser flops reset to 1 so a reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= key_i;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_press <= w_press_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_press_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_key_s) begin
          w_state_next = ST_DEB_DN;
          w_cnt_next   = CNT_W'(1);
        end
      end
      ST_DEB_DN: begin
        if (w_key_s) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ST_DOWN;
          w_cnt_next   = '0;
          w_press_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_DOWN: begin
        if (w_key_s) begin
          w_state_next = ST_DEB_UP;
          w_cnt_next   = CNT_W'(1);
        end
      end
      ST_DEB_UP: begin
        // A bounce back low returns to DOWN without a new press.
        if (!w_key_s) begin
          w_state_next = ST_DOWN;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign press_o     = r_press;
  assign press_set_o = w_press_next;

endmodule

// File: rtl/led_key_ctrl.sv
// led_key_ctrl: button-driven direction toggle and periodic step enable
// feeding the LED shifter FSM.
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   key_i    raw asynchronous button, 0 = pressed
//   en_i     run enable; while low the tick counter holds and step_o stays 0
//   mode_o   direction, MODE_LEFT / MODE_RIGHT, toggles on each accepted press
//   press_o  one-cycle pulse per accepted press
//   step_o   one-cycle step enable every TICK_CYCLES enabled cycles
module led_key_ctrl
  import led_pkg::*;
#(
  parameter int DEB_CYCLES  = 20,  // >= 2
  parameter int TICK_CYCLES = 50   // >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  input  logic en_i,
  output logic mode_o,
  output logic press_o,
  output logic step_o
);

  localparam int TICK_W = $clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  logic              w_press_set;
  logic              r_mode;
  logic [TICK_W-1:0] r_tick;
  logic              r_step;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk        (clk),
    .rst        (rst),
    .key_i      (key_i),
    .press_o    (press_o),
    .press_set_o(w_press_set)
  );

  // A press restarts the step period regardless of en_i and overrides a
  // coincident wrap, so the first step in the new direction is a full
  // period after the toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_LEFT;
      r_tick <= '0;
      r_step <= 1'b0;
    end else begin
      if (w_press_set) begin
        r_mode <= ~r_mode;
      end
      if (w_press_set) begin
        r_tick <= '0;
        r_step <= 1'b0;
      end else if (en_i) begin
        if (r_tick == TICK_LAST) begin
          r_tick <= '0;
          r_step <= 1'b1;
        end else begin
          r_tick <= r_tick + 1'b1;
          r_step <= 1'b0;
        end
      end else begin
        r_step <= 1'b0;
      end
    end
  end

  assign mode_o = r_mode;
  assign step_o = r_step;

endmodule
